alu_issue_queue: RTL and testbench
==================================

# alu_issue_queue

Parametrised ALU reservation station with oldest-first select. It sits between decode and a shared, pipelined ALU. Decode allocates entries through a valid/ready handshake. Entries capture missing operands from `NUM_CDB` result broadcast channels. One ready entry per cycle is issued to the ALU under backpressure. Unlike the per-entry-ALU station, it supports age-ordered issue, multiple wakeup channels, same-cycle allocation bypass, occupancy reporting and flush.

## Interface
- `DEPTH`, 8, number of entries (power of two, ≥2)
- `IDX_W`, 3, log2(`DEPTH`)
- `ROB_IDX_W`, 4, ROB tag width
- `XLEN`, 32, operand width
- `NUM_CDB`, 2, number of broadcast channels (≥1)

Ports:
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  reset, asynchronous, active-low (0 = reset)
- `flush`  in  1  synchronous squash of all entries
- `alloc_valid`  in  1  decode presents an instruction
- `alloc_ready`  out  1  queue can accept this cycle
- `alloc_aluop`  in  alu_ops  operation (rv32i_types)
- `alloc_rob_tag`  in  ROB_IDX_W  destination ROB tag
- `alloc_v1`, `alloc_v2`  in  1  operand already a value
- `alloc_op1`, `alloc_op2`  in  XLEN  value if valid, else producer tag in bits [ROB_IDX_W-1:0]
- `cdb_valid`  in  NUM_CDB  per-channel broadcast valid
- `cdb_tag`  in  NUM_CDB×ROB_IDX_W  broadcast producer tags
- `cdb_data`  in  NUM_CDB×XLEN  broadcast values
- `issue_valid`  out  1  a ready entry is presented
- `issue_ready`  in  1  ALU accepts
- `issue_aluop`  out  alu_ops  selected entry's operation
- `issue_op1`, `issue_op2`  out  XLEN  selected entry's operand values
- `issue_rob_tag`  out  ROB_IDX_W  selected entry's destination tag
- `count`  out  IDX_W+1  occupied entries, 0..DEPTH

## Operation
- Entry state: `valid`, `aluop`, `rob_tag`, `v1`/`op1`, `v2`/`op2`, and an age rank. An entry is ready when `valid & v1 & v2`.
- `alloc_ready = (count != DEPTH)`. The flag depends only on registered state; a slot freed by issue in the same cycle is not reusable until the next cycle.
- An allocation fires on `alloc_valid & alloc_ready & ~flush`.
  - It writes the lowest-index free entry.
  - The new entry is the youngest.
- Allocation bypass: if `alloc_vN=0` and some `cdb_valid[k]` has `cdb_tag[k]==alloc_opN[ROB_IDX_W-1:0]` in the same cycle, the entry is stored with `vN=1` and `opN=cdb_data[k]`.
- Wakeup: for each valid entry with `vN=0` and a tag match on any valid channel, set `vN=1` and `opN=cdb_data[k]` at the edge. If several channels match, the lowest k wins.
- Select: among ready entries, present the oldest (earliest allocated). Its fields drive the `issue_*` outputs combinationally from registered state.
- Issue fires on `issue_valid & issue_ready`; the selected entry's `valid` is cleared at the edge.
- `issue_*` data outputs are don't-care while `issue_valid=0`. They must hold stable while `issue_valid=1 & issue_ready=0`, unless an older entry becomes ready.
- `count_next = count + alloc_fire − issue_fire`, saturating behaviour is never needed. Simultaneous alloc and issue leaves `count` unchanged.
- `flush=1`: at the next edge all `valid` bits clear and `count` goes to 0. Flush overrides allocation, issue bookkeeping and wakeup.
  - `alloc_ready` still reflects pre-flush `count` in the flush cycle.
  - `issue_valid` may still be 1 in the flush cycle; the ALU side must discard that issue.
- Age ordering survives arbitrary interleaving of allocation and out-of-order issue. Relative order among remaining entries never changes.

## Timing
- Reset (asynchronous, `rst=0`): all `valid=0`, `count=0`, `alloc_ready=1`, `issue_valid=0`, issue data outputs 0.
- Reset deassertion is synchronised externally; the first allocation may occur on the first edge with `rst=1`.
- Allocation to earliest issue:
  - 1 cycle if both operands are valid or bypassed at allocation (entry presented the cycle after alloc).
  - Wakeup to earliest issue: 1 cycle (broadcast on cycle t, `issue_valid` on t+1).
- Throughput: one allocation and one issue per cycle, sustained when `DEPTH` ≥ 2 and the ALU never stalls.
- `count` and `alloc_ready` are registered-state functions; there is no combinational path from `alloc_valid` or `issue_ready` to `alloc_ready`.
- Combinational paths exist only from registered state to `issue_*`; there is no path from `cdb_*` to `issue_*`.

## Test plan
- **Reset:** assert `rst=0` mid-run with 5 entries held. Required: immediately `count=0`, `issue_valid=0`, `alloc_ready=1`. After release, a fresh allocation issues normally.
- **Fill/full:** allocate 8 entries with operands waiting on tag 3, `issue_ready=1`. Required: `count=8`, `alloc_ready=0`, no issue. Then broadcast tag 3 with data 0x55 on channel 1. Required: next cycle `issue_valid=1` with `op1=0x55` for the oldest entry, entries then issued in allocation order over 8 cycles, `count` decrements to 0.
- **Age order:** allocate A (waits tag 5), B (ready), C (waits tag 6). Broadcast tags 5 and 6 together on channels 0/1. Required issue order: B, A, C.
- **Bypass and collision:** allocate with `alloc_v2=0` tag 9 while channel 0 broadcasts tag 9 with data 0xDEAD. Required: the entry issues the next cycle with `op2=0xDEAD`. Both channels broadcast tag 2 with different data. Required: channel 0 data captured.
- **Backpressure:** two ready entries, `issue_ready=0` for 3 cycles. Required: outputs stable on the oldest, `count=2`. Raise `issue_ready` with simultaneous allocation. Required: `count` stays 2.
- **Flush:** 6 entries, flush with concurrent `alloc_valid`. Required: next cycle `count=0`, `issue_valid=0`, and the flushed-cycle allocation is not stored.

Source files
------------

// File: rtl/alu_issue_queue.sv
// ---------------------------------------------------------------------------
// rv32i_types: ALU operation encoding shared with decode and the ALU.
// ---------------------------------------------------------------------------
package rv32i_types;
    typedef enum logic [3:0] {
        alu_add  = 4'd0,
        alu_sll  = 4'd1,
        alu_sra  = 4'd2,
        alu_sub  = 4'd3,
        alu_xor  = 4'd4,
        alu_srl  = 4'd5,
        alu_or   = 4'd6,
        alu_and  = 4'd7,
        alu_slt  = 4'd8,
        alu_sltu = 4'd9
    } alu_ops;
endpackage

// ---------------------------------------------------------------------------
// alu_issue_queue
//   Reservation station in front of a shared pipelined ALU. Decode allocates
//   entries through alloc_valid/alloc_ready; entries capture missing operands
//   from NUM_CDB broadcast channels (lowest channel wins on a multi-match);
//   the oldest ready entry is presented on issue_* and leaves on
//   issue_valid & issue_ready. flush squashes every entry at the next edge.
//
// Ports
//   clk, rst (async, active-low), flush
//   alloc_valid/alloc_ready, alloc_aluop, alloc_rob_tag,
//   alloc_v1/alloc_op1, alloc_v2/alloc_op2  (opN holds a producer tag when vN=0)
//   cdb_valid[NUM_CDB], cdb_tag[NUM_CDB*ROB_IDX_W], cdb_data[NUM_CDB*XLEN]
//     (channel k occupies slice k of each packed vector)
//   issue_valid/issue_ready, issue_aluop, issue_op1, issue_op2, issue_rob_tag
//   count  occupied entries 0..DEPTH
// ---------------------------------------------------------------------------
module alu_issue_queue
    import rv32i_types::*;
#(
    parameter int DEPTH     = 8,
    parameter int IDX_W     = 3,
    parameter int ROB_IDX_W = 4,
    parameter int XLEN      = 32,
    parameter int NUM_CDB   = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic                           alloc_valid,
    output logic                           alloc_ready,
    input  alu_ops                         alloc_aluop,
    input  logic [ROB_IDX_W-1:0]           alloc_rob_tag,
    input  logic                           alloc_v1,
    input  logic                           alloc_v2,
    input  logic [XLEN-1:0]                alloc_op1,
    input  logic [XLEN-1:0]                alloc_op2,
    input  logic [NUM_CDB-1:0]             cdb_valid,
    input  logic [NUM_CDB*ROB_IDX_W-1:0]   cdb_tag,
    input  logic [NUM_CDB*XLEN-1:0]        cdb_data,
    output logic                           issue_valid,
    input  logic                           issue_ready,
    output alu_ops                         issue_aluop,
    output logic [XLEN-1:0]                issue_op1,
    output logic [XLEN-1:0]                issue_op2,
    output logic [ROB_IDX_W-1:0]           issue_rob_tag,
    output logic [IDX_W:0]                 count
);

    // Returns {hit, data}. Channels are scanned high to low so the lowest
    // matching channel is the one left in the result.
    function automatic logic [XLEN:0] cdb_lookup(
        input logic [ROB_IDX_W-1:0]         tag,
        input logic [NUM_CDB-1:0]           vld,
        input logic [NUM_CDB*ROB_IDX_W-1:0] tags,
        input logic [NUM_CDB*XLEN-1:0]      data
    );
        logic [XLEN:0] res;
        res = '0;
        for (int k = NUM_CDB - 1; k >= 0; k--) begin
            res = (vld[k] && (tags[k*ROB_IDX_W +: ROB_IDX_W] == tag))
                  ? {1'b1, data[k*XLEN +: XLEN]} : res;
        end
        return res;
    endfunction

    // Entry state
    logic [DEPTH-1:0]     valid_q, valid_d;
    logic [DEPTH-1:0]     v1_q, v1_d;
    logic [DEPTH-1:0]     v2_q, v2_d;
    alu_ops               aluop_q   [DEPTH];
    alu_ops               aluop_d   [DEPTH];
    logic [ROB_IDX_W-1:0] rob_tag_q [DEPTH];
    logic [ROB_IDX_W-1:0] rob_tag_d [DEPTH];
    logic [XLEN-1:0]      op1_q     [DEPTH];
    logic [XLEN-1:0]      op1_d     [DEPTH];
    logic [XLEN-1:0]      op2_q     [DEPTH];
    logic [XLEN-1:0]      op2_d     [DEPTH];
    // Age matrix: older_q[i][j]=1 means entry j was allocated before entry i.
    // Rows are only written on allocation, so the relative order of the
    // survivors never changes when other entries leave.
    logic [DEPTH-1:0]     older_q   [DEPTH];
    logic [DEPTH-1:0]     older_d   [DEPTH];
    logic [IDX_W:0]       count_q, count_d;

    logic [DEPTH-1:0]     ready_s;
    logic [IDX_W-1:0]     sel_idx_s;
    logic                 sel_found_s;
    logic [IDX_W-1:0]     free_idx_s;
    logic                 alloc_fire_s;
    logic                 issue_fire_s;
    logic [XLEN:0]        wake1_s [DEPTH];
    logic [XLEN:0]        wake2_s [DEPTH];
    logic [XLEN:0]        byp1_s;
    logic [XLEN:0]        byp2_s;

    // Oldest-ready select: the one ready entry with no ready entry older than it.
    always_comb begin
        ready_s     = valid_q & v1_q & v2_q;
        sel_idx_s   = '0;
        sel_found_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ready_s[i] && ((older_q[i] & ready_s) == '0)) begin
                sel_idx_s   = IDX_W'(i);
                sel_found_s = 1'b1;
            end else begin
                sel_found_s = sel_found_s;
            end
        end
    end

    // Lowest-index free slot; alloc_ready guarantees one exists when used.
    always_comb begin
        free_idx_s = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_idx_s = IDX_W'(i);
            end else begin
                free_idx_s = free_idx_s;
            end
        end
    end

    // Broadcast matches for every waiting operand and for the incoming operands.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            wake1_s[i] = cdb_lookup(op1_q[i][ROB_IDX_W-1:0], cdb_valid, cdb_tag, cdb_data);
            wake2_s[i] = cdb_lookup(op2_q[i][ROB_IDX_W-1:0], cdb_valid, cdb_tag, cdb_data);
        end
        byp1_s = cdb_lookup(alloc_op1[ROB_IDX_W-1:0], cdb_valid, cdb_tag, cdb_data);
        byp2_s = cdb_lookup(alloc_op2[ROB_IDX_W-1:0], cdb_valid, cdb_tag, cdb_data);
    end

    assign alloc_ready  = (count_q != (IDX_W+1)'(DEPTH));
    assign alloc_fire_s = alloc_valid & alloc_ready & ~flush;
    assign issue_fire_s = sel_found_s & issue_ready;

    // Next-state: wakeup, issue retire, allocation, occupancy, flush.
    always_comb begin
        valid_d   = valid_q;
        v1_d      = v1_q;
        v2_d      = v2_q;
        aluop_d   = aluop_q;
        rob_tag_d = rob_tag_q;
        op1_d     = op1_q;
        op2_d     = op2_q;
        older_d   = older_q;
        count_d   = count_q;

        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && !v1_q[i] && wake1_s[i][XLEN]) begin
                v1_d[i]  = 1'b1;
                op1_d[i] = wake1_s[i][XLEN-1:0];
            end else begin
                v1_d[i]  = v1_q[i];
            end
            if (valid_q[i] && !v2_q[i] && wake2_s[i][XLEN]) begin
                v2_d[i]  = 1'b1;
                op2_d[i] = wake2_s[i][XLEN-1:0];
            end else begin
                v2_d[i]  = v2_q[i];
            end
        end

        if (issue_fire_s) begin
            valid_d[sel_idx_s] = 1'b0;
        end else begin
            valid_d = valid_d;
        end

        if (alloc_fire_s) begin
            // The new entry is younger than every survivor and older than none.
            for (int j = 0; j < DEPTH; j++) begin
                older_d[j][free_idx_s] = 1'b0;
            end
            older_d[free_idx_s]   = valid_d;
            valid_d[free_idx_s]   = 1'b1;
            aluop_d[free_idx_s]   = alloc_aluop;
            rob_tag_d[free_idx_s] = alloc_rob_tag;
            v1_d[free_idx_s]      = alloc_v1 | byp1_s[XLEN];
            v2_d[free_idx_s]      = alloc_v2 | byp2_s[XLEN];
            op1_d[free_idx_s]     = (!alloc_v1 && byp1_s[XLEN]) ? byp1_s[XLEN-1:0] : alloc_op1;
            op2_d[free_idx_s]     = (!alloc_v2 && byp2_s[XLEN]) ? byp2_s[XLEN-1:0] : alloc_op2;
        end else begin
            valid_d = valid_d;
        end

        case ({alloc_fire_s, issue_fire_s})
            2'b10:   count_d = count_q + (IDX_W+1)'(1);
            2'b01:   count_d = count_q - (IDX_W+1)'(1);
            default: count_d = count_q;
        endcase

        if (flush) begin
            valid_d = '0;
            count_d = '0;
        end else begin
            count_d = count_d;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            v1_q    <= '0;
            v2_q    <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                aluop_q[i]   <= alu_add;
                rob_tag_q[i] <= '0;
                op1_q[i]     <= '0;
                op2_q[i]     <= '0;
                older_q[i]   <= '0;
            end
        end else begin
            valid_q <= valid_d;
            v1_q    <= v1_d;
            v2_q    <= v2_d;
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                aluop_q[i]   <= aluop_d[i];
                rob_tag_q[i] <= rob_tag_d[i];
                op1_q[i]     <= op1_d[i];
                op2_q[i]     <= op2_d[i];
                older_q[i]   <= older_d[i];
            end
        end
    end

    // Issue fields come straight from registered state and read as zero when
    // nothing is presented.
    assign issue_valid   = sel_found_s;
    assign issue_aluop   = sel_found_s ? aluop_q[sel_idx_s]   : alu_add;
    assign issue_op1     = sel_found_s ? op1_q[sel_idx_s]     : '0;
    assign issue_op2     = sel_found_s ? op2_q[sel_idx_s]     : '0;
    assign issue_rob_tag = sel_found_s ? rob_tag_q[sel_idx_s] : '0;
    assign count         = count_q;

endmodule

// File: tb/tb_alu_issue_queue.sv
module tb_alu_issue_queue;
    import rv32i_types::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        alloc_valid = 1'b0;
    logic        alloc_ready;
    alu_ops      alloc_aluop = alu_add;
    logic [3:0]  alloc_rob_tag = 4'd0;
    logic        alloc_v1 = 1'b0;
    logic        alloc_v2 = 1'b0;
    logic [31:0] alloc_op1 = 32'd0;
    logic [31:0] alloc_op2 = 32'd0;
    logic [1:0]  cdb_valid = 2'b00;
    logic [7:0]  cdb_tag = 8'd0;
    logic [63:0] cdb_data = 64'd0;
    logic        issue_valid;
    logic        issue_ready = 1'b0;
    alu_ops      issue_aluop;
    logic [31:0] issue_op1;
    logic [31:0] issue_op2;
    logic [3:0]  issue_rob_tag;
    logic [3:0]  count;

    int total = 0;
    int bad = 0;

    alu_issue_queue #(.DEPTH(8), .IDX_W(3), .ROB_IDX_W(4), .XLEN(32), .NUM_CDB(2)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_aluop(alloc_aluop),
        .alloc_rob_tag(alloc_rob_tag), .alloc_v1(alloc_v1), .alloc_v2(alloc_v2),
        .alloc_op1(alloc_op1), .alloc_op2(alloc_op2),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_aluop(issue_aluop),
        .issue_op1(issue_op1), .issue_op2(issue_op2), .issue_rob_tag(issue_rob_tag),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alloc(input alu_ops op, input logic [3:0] tag,
                         input logic v1, input logic [31:0] o1,
                         input logic v2, input logic [31:0] o2);
        alloc_valid = 1'b1; alloc_aluop = op; alloc_rob_tag = tag;
        alloc_v1 = v1; alloc_op1 = o1; alloc_v2 = v2; alloc_op2 = o2;
        tick();
        alloc_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick(); tick();
        rst = 1'b1;
        total++; if (count !== 4'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", count); end
        total++; if (alloc_ready !== 1'b1) begin bad++; $display("FAIL reset_alloc_ready: got %b want 1", alloc_ready); end
        total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL reset_issue_valid: got %b want 0", issue_valid); end
        total++; if (issue_op1 !== 32'd0 || issue_rob_tag !== 4'd0) begin bad++; $display("FAIL reset_issue_data: got %h/%h want 0/0", issue_op1, issue_rob_tag); end
    endtask

    task automatic test_fill_full();
        issue_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            alloc(alu_add, 4'(i), 1'b0, 32'd3, 1'b1, 32'(i));
            total++; if (count !== 4'(i + 1)) begin bad++; $display("FAIL fill_count_%0d: got %0d want %0d", i, count, i + 1); end
            total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL fill_no_issue_%0d: got %b want 0", i, issue_valid); end
        end
        total++; if (alloc_ready !== 1'b0) begin bad++; $display("FAIL full_alloc_ready: got %b want 0", alloc_ready); end
        cdb_valid = 2'b10; cdb_tag = {4'd3, 4'd0}; cdb_data = {32'h55, 32'h0};
        tick();
        cdb_valid = 2'b00;
        for (int i = 0; i < 8; i++) begin
            total++; if (issue_valid !== 1'b1 || issue_rob_tag !== 4'(i)) begin bad++; $display("FAIL fill_issue_%0d: got v=%b tag=%0d want v=1 tag=%0d", i, issue_valid, issue_rob_tag, i); end
            total++; if (issue_op1 !== 32'h55 || issue_op2 !== 32'(i)) begin bad++; $display("FAIL fill_ops_%0d: got %h/%h want 55/%h", i, issue_op1, issue_op2, i); end
            total++; if (count !== 4'(8 - i)) begin bad++; $display("FAIL fill_drain_count_%0d: got %0d want %0d", i, count, 8 - i); end
            tick();
        end
        total++; if (count !== 4'd0 || issue_valid !== 1'b0 || alloc_ready !== 1'b1) begin bad++; $display("FAIL fill_empty: got c=%0d v=%b r=%b want 0/0/1", count, issue_valid, alloc_ready); end
    endtask

    task automatic test_age_order();
        issue_ready = 1'b0;
        alloc(alu_add, 4'd1, 1'b0, 32'd5,   1'b1, 32'hA);
        alloc(alu_or,  4'd2, 1'b1, 32'h11,  1'b1, 32'h22);
        alloc(alu_and, 4'd3, 1'b1, 32'hC,   1'b0, 32'd6);
        total++; if (issue_valid !== 1'b1 || issue_rob_tag !== 4'd2) begin bad++; $display("FAIL age_first_B: got v=%b tag=%0d want v=1 tag=2", issue_valid, issue_rob_tag); end
        issue_ready = 1'b1;
        cdb_valid = 2'b11; cdb_tag = {4'd6, 4'd5}; cdb_data = {32'h66, 32'h55};
        tick();
        cdb_valid = 2'b00;
        total++; if (issue_valid !== 1'b1 || issue_rob_tag !== 4'd1 || issue_op1 !== 32'h55 || issue_op2 !== 32'hA) begin bad++; $display("FAIL age_second_A: got v=%b tag=%0d op=%h/%h want 1/1/55/a", issue_valid, issue_rob_tag, issue_op1, issue_op2); end
        tick();
        total++; if (issue_valid !== 1'b1 || issue_rob_tag !== 4'd3 || issue_op1 !== 32'hC || issue_op2 !== 32'h66 || issue_aluop !== alu_and) begin bad++; $display("FAIL age_third_C: got v=%b tag=%0d op=%h/%h want 1/3/c/66", issue_valid, issue_rob_tag, issue_op1, issue_op2); end
        tick();
        total++; if (count !== 4'd0 || issue_valid !== 1'b0) begin bad++; $display("FAIL age_empty: got c=%0d v=%b want 0/0", count, issue_valid); end
    endtask

    task automatic test_bypass_collision();
        issue_ready = 1'b1;
        cdb_valid = 2'b01; cdb_tag = {4'd0, 4'd9}; cdb_data = {32'h0, 32'hDEAD};
        alloc(alu_sub, 4'd7, 1'b1, 32'h100, 1'b0, 32'd9);
        cdb_valid = 2'b00;
        total++; if (issue_valid !== 1'b1 || issue_rob_tag !== 4'd7 || issue_op1 !== 32'h100 || issue_op2 !== 32'hDEAD) begin bad++; $display("FAIL bypass_issue: got v=%b tag=%0d op=%h/%h want 1/7/100/dead", issue_valid, issue_rob_tag, issue_op1, issue_op2); end
        tick();
        issue_ready = 1'b0;
        alloc(alu_add, 4'd4, 1'b0, 32'd2, 1'b1, 32'h3);
        total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL collision_wait: got %b want 0", issue_valid); end
        cdb_valid = 2'b11; cdb_tag = {4'd2, 4'd2}; cdb_data = {32'h2222, 32'h1111};
        tick();
        cdb_valid = 2'b00;
        total++; if (issue_valid !== 1'b1 || issue_op1 !== 32'h1111) begin bad++; $display("FAIL collision_ch0: got v=%b op1=%h want 1/1111", issue_valid, issue_op1); end
        issue_ready = 1'b1;
        tick();
        total++; if (count !== 4'd0) begin bad++; $display("FAIL collision_drain: got %0d want 0", count); end
    endtask

    task automatic test_backpressure();
        issue_ready = 1'b0;
        alloc(alu_sub, 4'd5, 1'b1, 32'h50, 1'b1, 32'h51);
        alloc(alu_xor, 4'd6, 1'b1, 32'h60, 1'b1, 32'h61);
        for (int i = 0; i < 3; i++) begin
            total++; if (issue_valid !== 1'b1 || issue_rob_tag !== 4'd5 || issue_op1 !== 32'h50 || issue_op2 !== 32'h51 || issue_aluop !== alu_sub) begin bad++; $display("FAIL bp_hold_%0d: got v=%b tag=%0d op=%h/%h want 1/5/50/51", i, issue_valid, issue_rob_tag, issue_op1, issue_op2); end
            total++; if (count !== 4'd2) begin bad++; $display("FAIL bp_count_%0d: got %0d want 2", i, count); end
            tick();
        end
        issue_ready = 1'b1;
        alloc(alu_or, 4'd8, 1'b1, 32'h80, 1'b1, 32'h81);
        total++; if (count !== 4'd2 || issue_rob_tag !== 4'd6) begin bad++; $display("FAIL bp_simul: got c=%0d tag=%0d want 2/6", count, issue_rob_tag); end
        tick();
        total++; if (count !== 4'd1 || issue_rob_tag !== 4'd8 || issue_op1 !== 32'h80) begin bad++; $display("FAIL bp_last: got c=%0d tag=%0d op1=%h want 1/8/80", count, issue_rob_tag, issue_op1); end
        tick();
        total++; if (count !== 4'd0) begin bad++; $display("FAIL bp_drain: got %0d want 0", count); end
    endtask

    task automatic test_flush();
        issue_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            alloc(alu_add, 4'(i + 1), 1'b1, 32'(i), 1'b1, 32'(i));
        end
        total++; if (count !== 4'd6) begin bad++; $display("FAIL flush_pre_count: got %0d want 6", count); end
        flush = 1'b1;
        alloc_valid = 1'b1; alloc_rob_tag = 4'd15; alloc_v1 = 1'b1; alloc_v2 = 1'b1;
        #1;
        total++; if (alloc_ready !== 1'b1) begin bad++; $display("FAIL flush_cycle_ready: got %b want 1", alloc_ready); end
        tick();
        flush = 1'b0; alloc_valid = 1'b0;
        total++; if (count !== 4'd0 || issue_valid !== 1'b0 || alloc_ready !== 1'b1) begin bad++; $display("FAIL flush_cleared: got c=%0d v=%b r=%b want 0/0/1", count, issue_valid, alloc_ready); end
        tick();
        total++; if (count !== 4'd0 || issue_valid !== 1'b0) begin bad++; $display("FAIL flush_alloc_dropped: got c=%0d v=%b want 0/0", count, issue_valid); end
    endtask

    task automatic test_reset_midrun();
        issue_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            alloc(alu_add, 4'(i), 1'b1, 32'h7, 1'b1, 32'h7);
        end
        total++; if (count !== 4'd5) begin bad++; $display("FAIL rst_pre_count: got %0d want 5", count); end
        #2 rst = 1'b0;
        #1;
        total++; if (count !== 4'd0 || issue_valid !== 1'b0 || alloc_ready !== 1'b1) begin bad++; $display("FAIL rst_async: got c=%0d v=%b r=%b want 0/0/1", count, issue_valid, alloc_ready); end
        tick();
        rst = 1'b1;
        issue_ready = 1'b1;
        alloc(alu_sll, 4'd9, 1'b1, 32'h9, 1'b1, 32'h19);
        total++; if (issue_valid !== 1'b1 || issue_rob_tag !== 4'd9 || issue_op2 !== 32'h19 || issue_aluop !== alu_sll) begin bad++; $display("FAIL rst_after_issue: got v=%b tag=%0d op2=%h want 1/9/19", issue_valid, issue_rob_tag, issue_op2); end
        tick();
        total++; if (count !== 4'd0) begin bad++; $display("FAIL rst_after_drain: got %0d want 0", count); end
    endtask

    initial begin
        test_reset();
        test_fill_full();
        test_age_order();
        test_bypass_collision();
        test_backpressure();
        test_flush();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
